// File: rtl/mmix_mem_bridge.sv
// Bridges the MMIX mem_* request port onto a 16-bit Avalon-MM master, one beat per halfword.
// Optional per-beat watchdog enabled by defining MMIX_MEM_TIMEOUT_EN.
module mmix_mem_bridge #(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       mem_address,
  input  logic [1:0]        mem_datasize,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       mem_writedata,
  output logic [63:0]       mem_readdata,
  output logic              mem_done,
  output logic              mem_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_is_write, w_is_write_nxt;
  logic                r_is_byte, w_is_byte_nxt;
  logic                r_byte_odd, w_byte_odd_nxt;
  logic [1:0]          r_beats_left, w_beats_left_nxt;
  logic [63:0]         r_wsh, w_wsh_nxt;
  logic [63:0]         r_acc, w_acc_nxt;
  logic [ADDR_W-1:0]   r_avm_address, w_addr_nxt;
  logic                r_avm_read, w_rd_nxt;
  logic                r_avm_write, w_wr_nxt;
  logic [15:0]         r_avm_writedata, w_wdata_nxt;
  logic [1:0]          r_avm_byteenable, w_be_nxt;
  logic [63:0]         r_mem_readdata, w_rdata_nxt;
  logic                r_mem_done, w_done_nxt;
  logic                r_mem_err, w_err_nxt;
  logic                w_beat_adv;

  logic [ADDR_W-1:0]   w_addr_in, w_aligned;
  logic [63:0]         w_wlj;
  logic [1:0]          w_nbeats_m1;
  logic [7:0]          w_lane;

`ifdef MMIX_MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    r_tmo_cnt, w_tmo_nxt;
  logic                w_unused;
  assign w_unused = ^mem_address[63:ADDR_W];
`else
  logic                w_unused;
  assign w_unused = ^{mem_address[63:ADDR_W], 32'(TIMEOUT_CYCLES), w_beat_adv};
`endif

  assign w_addr_in = mem_address[ADDR_W-1:0];
  assign w_lane    = r_byte_odd ? avm_readdata[7:0] : avm_readdata[15:8];

  // Request decode: size-aligned address, write data left-justified so beats shift out MSB first
  always_comb begin
    w_aligned   = w_addr_in;
    w_wlj       = mem_writedata;
    w_nbeats_m1 = 2'd0;
    case (mem_datasize)
      2'd0: begin
        w_wlj = {mem_writedata[7:0], mem_writedata[7:0], 48'd0};
      end
      2'd1: begin
        w_aligned = {w_addr_in[ADDR_W-1:1], 1'b0};
        w_wlj     = {mem_writedata[15:0], 48'd0};
      end
      2'd2: begin
        w_aligned   = {w_addr_in[ADDR_W-1:2], 2'b00};
        w_wlj       = {mem_writedata[31:0], 32'd0};
        w_nbeats_m1 = 2'd1;
      end
      default: begin
        w_aligned   = {w_addr_in[ADDR_W-1:3], 3'b000};
        w_nbeats_m1 = 2'd3;
      end
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_is_write_nxt   = r_is_write;
    w_is_byte_nxt    = r_is_byte;
    w_byte_odd_nxt   = r_byte_odd;
    w_beats_left_nxt = r_beats_left;
    w_wsh_nxt        = r_wsh;
    w_acc_nxt        = r_acc;
    w_addr_nxt       = r_avm_address;
    w_rd_nxt         = 1'b0;
    w_wr_nxt         = 1'b0;
    w_wdata_nxt      = r_avm_writedata;
    w_be_nxt         = r_avm_byteenable;
    w_rdata_nxt      = r_mem_readdata;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_mem_err;
    w_beat_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_write || mem_read) begin
          w_state_nxt      = S_ISSUE;
          w_is_write_nxt   = mem_write;
          w_is_byte_nxt    = (mem_datasize == 2'd0);
          w_byte_odd_nxt   = w_addr_in[0];
          w_beats_left_nxt = w_nbeats_m1;
          w_addr_nxt       = {w_aligned[ADDR_W-1:1], 1'b0};
          w_rd_nxt         = !mem_write;
          w_wr_nxt         = mem_write;
          w_wdata_nxt      = w_wlj[63:48];
          w_wsh_nxt        = {w_wlj[47:0], 16'd0};
          w_be_nxt         = (mem_datasize != 2'd0) ? 2'b11 : (w_addr_in[0] ? 2'b01 : 2'b10);
          w_acc_nxt        = '0;
        end
      end
      S_ISSUE: begin
        if (avm_waitrequest) begin
          w_rd_nxt = r_avm_read;
          w_wr_nxt = r_avm_write;
        end else if (r_is_write) begin
          if (r_beats_left == 2'd0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_beat_adv       = 1'b1;
            w_wr_nxt         = 1'b1;
            w_addr_nxt       = r_avm_address + ADDR_W'(2);
            w_wdata_nxt      = r_wsh[63:48];
            w_wsh_nxt        = {r_wsh[47:0], 16'd0};
            w_beats_left_nxt = r_beats_left - 2'd1;
          end
        end else begin
          w_state_nxt = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (avm_readdatavalid) begin
          w_acc_nxt = r_is_byte ? {56'd0, w_lane} : {r_acc[47:0], avm_readdata};
          if (r_beats_left == 2'd0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_rdata_nxt = w_acc_nxt;
          end else begin
            w_state_nxt      = S_ISSUE;
            w_rd_nxt         = 1'b1;
            w_addr_nxt       = r_avm_address + ADDR_W'(2);
            w_beats_left_nxt = r_beats_left - 2'd1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef MMIX_MEM_TIMEOUT_EN
    // Watchdog abort overrides whatever the beat was doing
    if ((r_state == S_ISSUE || r_state == S_WAIT_RD) &&
        r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      w_state_nxt = S_DONE;
      w_rd_nxt    = 1'b0;
      w_wr_nxt    = 1'b0;
      w_done_nxt  = 1'b1;
      w_rdata_nxt = '1;
      w_err_nxt   = 1'b1;
      w_beat_adv  = 1'b0;
    end
    if ((r_state == S_ISSUE || r_state == S_WAIT_RD) && w_state_nxt == r_state && !w_beat_adv)
      w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
    else
      w_tmo_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_is_write       <= 1'b0;
      r_is_byte        <= 1'b0;
      r_byte_odd       <= 1'b0;
      r_beats_left     <= 2'd0;
      r_wsh            <= '0;
      r_acc            <= '0;
      r_avm_address    <= '0;
      r_avm_read       <= 1'b0;
      r_avm_write      <= 1'b0;
      r_avm_writedata  <= '0;
      r_avm_byteenable <= 2'b00;
      r_mem_readdata   <= '0;
      r_mem_done       <= 1'b0;
      r_mem_err        <= 1'b0;
`ifdef MMIX_MEM_TIMEOUT_EN
      r_tmo_cnt        <= '0;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_is_write       <= w_is_write_nxt;
      r_is_byte        <= w_is_byte_nxt;
      r_byte_odd       <= w_byte_odd_nxt;
      r_beats_left     <= w_beats_left_nxt;
      r_wsh            <= w_wsh_nxt;
      r_acc            <= w_acc_nxt;
      r_avm_address    <= w_addr_nxt;
      r_avm_read       <= w_rd_nxt;
      r_avm_write      <= w_wr_nxt;
      r_avm_writedata  <= w_wdata_nxt;
      r_avm_byteenable <= w_be_nxt;
      r_mem_readdata   <= w_rdata_nxt;
      r_mem_done       <= w_done_nxt;
      r_mem_err        <= w_err_nxt;
`ifdef MMIX_MEM_TIMEOUT_EN
      r_tmo_cnt        <= w_tmo_nxt;
`endif
    end
  end

  assign avm_address    = r_avm_address;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = r_avm_byteenable;
  assign mem_readdata   = r_mem_readdata;
  assign mem_done       = r_mem_done;
  assign mem_err        = r_mem_err;

endmodule
